// File: rtl/mmc1_mapper.sv
// mmc1_mapper: MMC1 serial-load register file with PRG/CHR SDRAM address translation and CIRAM A10 select.
// Optional MMC1_CONSEC_WRITE_FILTER_EN drops a write on the M2 cycle right after a committed one (RMW behaviour).
module mmc1_mapper #(
  parameter int ADDR_BITS = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m2,
  input  logic [14:0]          cpu_addr,
  input  logic [7:0]           cpu_data,
  input  logic                 cpu_rw,
  input  logic                 rom_ce,
  input  logic [12:0]          ppu_addr,
  input  logic                 run,
  input  logic [ADDR_BITS-1:0] prg_base,
  input  logic [ADDR_BITS-1:0] chr_base,
  output logic [ADDR_BITS-1:0] prg_addr,
  output logic [ADDR_BITS-1:0] chr_addr,
  output logic                 ciram_a10
);
  logic [1:0] m2_sync_q, rw_sync_q, ce_sync_q;
  logic m2_prev_q;
  logic wr_pend_q, wr_pend_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic [1:0] hold_sel_q, hold_sel_d;
  logic [4:0] control_q, control_d, chr0_q, chr0_d, chr1_q, chr1_d, shift_q, shift_d;
  logic [3:0] prg_q, prg_d;
  logic [2:0] count_q, count_d;
  logic [ADDR_BITS-1:0] prg_addr_q, prg_addr_d, chr_addr_q, chr_addr_d;
  logic ciram_a10_q, ciram_a10_d;
  logic fall, cap, commit;
  logic [4:0] shift_nx, chr_bank;
  logic [3:0] prg_bank;
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
  logic last_wr_q, last_wr_d;
`endif

  // Bring the asynchronous bus strobes into the clk domain and keep the previous m2 for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_sync_q <= '0;
      rw_sync_q <= 2'b11;
      ce_sync_q <= 2'b11;
      m2_prev_q <= 1'b0;
    end else begin
      m2_sync_q <= {m2_sync_q[0], m2};
      rw_sync_q <= {rw_sync_q[0], cpu_rw};
      ce_sync_q <= {ce_sync_q[0], rom_ce};
      m2_prev_q <= m2_sync_q[1];
    end
  end

  // Capture ROM writes while M2 is high, commit them into the serial loader on the M2 fall
  always_comb begin
    fall        = m2_prev_q & ~m2_sync_q[1];
    cap         = m2_sync_q[1] & ~ce_sync_q[1] & ~rw_sync_q[1];
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
    commit      = fall & wr_pend_q & run & ~last_wr_q;
    last_wr_d   = fall ? commit : last_wr_q;
`else
    commit      = fall & wr_pend_q & run;
`endif
    shift_nx    = {hold_data_q[0], shift_q[4:1]};
    hold_data_d = cap ? cpu_data : hold_data_q;
    hold_sel_d  = cap ? cpu_addr[14:13] : hold_sel_q;
    wr_pend_d   = fall ? 1'b0 : (cap | wr_pend_q);
    control_d   = control_q;
    chr0_d      = chr0_q;
    chr1_d      = chr1_q;
    prg_d       = prg_q;
    shift_d     = shift_q;
    count_d     = count_q;
    if (commit) begin
      if (hold_data_q[7]) begin
        shift_d   = '0;
        count_d   = '0;
        control_d = control_q | 5'h0C;
      end else if (count_q == 3'd4) begin
        shift_d   = '0;
        count_d   = '0;
        control_d = (hold_sel_q == 2'd0) ? shift_nx : control_q;
        chr0_d    = (hold_sel_q == 2'd1) ? shift_nx : chr0_q;
        chr1_d    = (hold_sel_q == 2'd2) ? shift_nx : chr1_q;
        prg_d     = (hold_sel_q == 2'd3) ? shift_nx[3:0] : prg_q;
      end else begin
        shift_d   = shift_nx;
        count_d   = count_q + 3'd1;
      end
    end
    if (!run) begin
      wr_pend_d = 1'b0;
      control_d = 5'h0C;
      chr0_d    = '0;
      chr1_d    = '0;
      prg_d     = '0;
      shift_d   = '0;
      count_d   = '0;
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
      last_wr_d = 1'b0;
`endif
    end
  end

  // Translate the current bus addresses through the bank registers
  always_comb begin
    prg_bank    = !control_q[3] ? {prg_q[3:1], cpu_addr[14]} :
                  !control_q[2] ? (cpu_addr[14] ? prg_q : 4'h0) :
                                  (cpu_addr[14] ? 4'hF : prg_q);
    chr_bank    = control_q[4] ? (ppu_addr[12] ? chr1_q : chr0_q) : {chr0_q[4:1], ppu_addr[12]};
    prg_addr_d  = prg_base + ADDR_BITS'({prg_bank, cpu_addr[13:0]});
    chr_addr_d  = chr_base + ADDR_BITS'({chr_bank, ppu_addr[11:0]});
    ciram_a10_d = control_q[1] ? (control_q[0] ? ppu_addr[11] : ppu_addr[10]) : control_q[0];
  end

  // Mapper state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_q   <= 1'b0;
      hold_data_q <= '0;
      hold_sel_q  <= '0;
      control_q   <= 5'h0C;
      chr0_q      <= '0;
      chr1_q      <= '0;
      prg_q       <= '0;
      shift_q     <= '0;
      count_q     <= '0;
      prg_addr_q  <= '0;
      chr_addr_q  <= '0;
      ciram_a10_q <= 1'b0;
    end else begin
      wr_pend_q   <= wr_pend_d;
      hold_data_q <= hold_data_d;
      hold_sel_q  <= hold_sel_d;
      control_q   <= control_d;
      chr0_q      <= chr0_d;
      chr1_q      <= chr1_d;
      prg_q       <= prg_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      prg_addr_q  <= prg_addr_d;
      chr_addr_q  <= chr_addr_d;
      ciram_a10_q <= ciram_a10_d;
    end
  end

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
  // Remember whether the last M2 cycle committed a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_wr_q <= 1'b0;
    else        last_wr_q <= last_wr_d;
  end
`endif

  assign prg_addr  = prg_addr_q;
  assign chr_addr  = chr_addr_q;
  assign ciram_a10 = ciram_a10_q;
endmodule

// File: tb/tb_mmc1_mapper.sv
// tb_mmc1_mapper: directed serial-load scenarios for mmc1_mapper with hand-computed addresses.
module tb_mmc1_mapper;
  logic clk = 0, rst_n = 0, m2 = 0, cpu_rw = 1, rom_ce = 1, run = 1, ciram_a10;
  logic [14:0] cpu_addr = '0;
  logic [7:0] cpu_data = '0;
  logic [12:0] ppu_addr = '0;
  logic [24:0] prg_base = 25'h0100000, chr_base = 25'h0200000, prg_addr, chr_addr;
  int total = 0, passed = 0;

  mmc1_mapper #(.ADDR_BITS(25)) dut (
    .clk(clk), .rst_n(rst_n), .m2(m2), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_rw(cpu_rw), .rom_ce(rom_ce), .ppu_addr(ppu_addr), .run(run),
    .prg_base(prg_base), .chr_base(chr_base), .prg_addr(prg_addr),
    .chr_addr(chr_addr), .ciram_a10(ciram_a10)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  task automatic bus(input logic [14:0] a, input logic [7:0] d, input logic w, input logic ce);
    @(negedge clk);
    cpu_addr = a; cpu_data = d; cpu_rw = ~w; rom_ce = ce;
    repeat (3) @(negedge clk);
    m2 = 1;
    repeat (6) @(negedge clk);
    m2 = 0;
    repeat (8) @(negedge clk);
    cpu_rw = 1; rom_ce = 1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d);
    bus(a, d, 1'b1, 1'b0);
    bus(a, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic ser(input logic [14:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) wr(a, {7'b0, v[i]});
  endtask

  task automatic at(input logic [14:0] a, input logic [12:0] p);
    cpu_addr = a; ppu_addr = p;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_prg", prg_addr, 0);
    chk("reset_chr", chr_addr, 0);
    chk("reset_a10", ciram_a10, 0);
    rst_n = 1;
    at(15'h4000, 13'h0400);
    chk("fixed_last_bank", prg_addr, 25'h013C000);
    chk("one_screen_lo", ciram_a10, 0);
    prg_base = 25'h1FF0000;
    at(15'h4000, 13'h0000);
    chk("prg_wrap", prg_addr, 25'h002C000);
    prg_base = 25'h0100000;
    ser(15'h6000, 5'h05);
    at(15'h0123, 13'h0000);
    chk("prg5_mode3", prg_addr, 25'h0114123);
    ser(15'h0000, 5'h12);
    ser(15'h4000, 5'h03);
    at(15'h0123, 13'h1ABC);
    chk("prg_32k_mode", prg_addr, 25'h0110123);
    chk("chr1_4k", chr_addr, 25'h0203ABC);
    at(15'h0123, 13'h0400);
    chk("vert_a10_hi", ciram_a10, 1);
    at(15'h0123, 13'h0800);
    chk("vert_a10_lo", ciram_a10, 0);
    for (int i = 0; i < 3; i++) wr(15'h2000, 8'h01);
    wr(15'h2000, 8'h80);
    ser(15'h2000, 5'h15);
    at(15'h4000, 13'h0ABC);
    chr_check: chk("chr0_after_abort", chr_addr, 25'h0215ABC);
    chk("abort_sets_prg_mode3", prg_addr, 25'h013C000);
    ser(15'h0000, 5'h13);
    at(15'h0000, 13'h0800);
    chk("horiz_a10_hi", ciram_a10, 1);
    at(15'h0000, 13'h0400);
    chk("horiz_a10_lo", ciram_a10, 0);
    chk("prg5_mode0", prg_addr, 25'h0110000);
    bus(15'h6000, 8'h01, 1'b1, 1'b0);
    bus(15'h6000, 8'h01, 1'b1, 1'b0);
    bus(15'h6000, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) wr(15'h6000, 8'h00);
    at(15'h0000, 13'h0000);
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
    chk("back_to_back", prg_addr, 25'h0110000);
`else
    chk("back_to_back", prg_addr, 25'h0108000);
`endif
    wr(15'h6000, 8'h01);
    wr(15'h6000, 8'h01);
    run = 0;
    repeat (4) @(negedge clk);
    run = 1;
    at(15'h4000, 13'h0000);
    chk("run0_last_bank", prg_addr, 25'h013C000);
    at(15'h0000, 13'h0000);
    chk("run0_prg_clear", prg_addr, 25'h0100000);
    ser(15'h6000, 5'h02);
    at(15'h0000, 13'h0000);
    chk("run0_shift_clear", prg_addr, 25'h0108000);
    for (int i = 0; i < 3; i++) wr(15'h6000, 8'h01);
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("midseq_reset_out", prg_addr, 0);
    rst_n = 1;
    ser(15'h6000, 5'h03);
    at(15'h0000, 13'h0000);
    chk("midseq_reset_seq", prg_addr, 25'h010C000);
    wr(15'h6000, 8'h01);
    wr(15'h6000, 8'h00);
    wr(15'h6000, 8'h00);
    bus(15'h6000, 8'h01, 1'b1, 1'b1);
    bus(15'h6000, 8'h00, 1'b0, 1'b0);
    wr(15'h6000, 8'h00);
    wr(15'h6000, 8'h00);
    at(15'h0000, 13'h0000);
    chk("romce_hi_ignored", prg_addr, 25'h0104000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
